output_pack: RTL and testbench

//   Downstream neighbour of the input pixel buffer. Takes the registered B/G/R byte triplet
//   it emits each cycle and packs the byte stream (B,G,R,B,G,R,...) into 32-bit little-endian words.

---
 rtl/output_pack_pkg.sv | 33 +++
 rtl/opack_fifo.sv | 65 ++++++
 rtl/output_pack.sv | 184 ++++++++++++++++++
 tb/tb_output_pack.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/output_pack_pkg.sv
`default_nettype none
// ============================================================================
// Module   : output_pack_pkg
// Purpose  : Shared definitions for the output byte packer: controller state
//            encoding, byte-lane geometry and the byte merge helper.
// Revision : 1.0 - initial release
// ============================================================================
package output_pack_pkg;

    // Frame controller states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PACK  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } opack_state_t;

    localparam logic [2:0] BYTES_PER_WORD  = 3'd4;
    localparam logic [2:0] BYTES_PER_PIXEL = 3'd3;

    // Places a new B/G/R triplet directly above the 'held' residue bytes.
    // Result bits [31:0] form the outgoing word, bits [47:32] the leftover.
    function automatic logic [47:0] merge_bytes(
        input logic [23:0] held,
        input logic [1:0]  held_cnt,
        input logic [23:0] triplet
    );
        merge_bytes = ({24'd0, triplet} << {held_cnt, 3'b000}) | {24'd0, held};
    endfunction

endpackage
`default_nettype wire

// File: rtl/opack_fifo.sv
`default_nettype none
// ============================================================================
// Module   : opack_fifo
// Purpose  : DEPTH x WIDTH synchronous word FIFO. The head entry is visible
//            combinationally on head_data (no read latency).
// Ports    : clk, rst_n (sync, active-low), push/push_data, pop,
//            head_data, count, full, empty
// Revision : 1.0 - initial release
// ============================================================================
module opack_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] C_PTR_ONE = AW'(1);
    localparam logic [AW:0]   C_CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   C_DEPTH   = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full      = (r_count == C_DEPTH);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head_data = r_mem[r_rd_ptr];
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed while count > 0.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/output_pack.sv
`default_nettype none
// ============================================================================
// Module   : output_pack
// Purpose  : Packs the B,G,R byte stream into 32-bit little-endian words
//            (byte0 = oldest), queues them in a word FIFO for the AHB write
//            path, and on end of frame flushes a zero-padded partial word
//            and pulses DONE once the FIFO has drained.
// Ports    : I_OPACK_HCLK / I_OPACK_HRESET_N (sync, active-low)
//            I_OPACK_PIXEL_B/G/R, I_OPACK_PIXEL_VALID   - input triplets
//            I_OPACK_FLUSH                              - end-of-frame pulse
//            I_OPACK_WREADY, O_OPACK_WDATA, O_OPACK_WVALID - word output
//            O_OPACK_STALL, O_OPACK_OVF, O_OPACK_DONE   - status
//            O_OPACK_BYTE_CNT                           - bytes this frame
// Config   : define OPACK_BYTE_CNT_EN to build the per-frame byte counter;
//            otherwise O_OPACK_BYTE_CNT is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module output_pack
    import output_pack_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             I_OPACK_HCLK,
    input  logic             I_OPACK_HRESET_N,
    input  logic [7:0]       I_OPACK_PIXEL_B,
    input  logic [7:0]       I_OPACK_PIXEL_G,
    input  logic [7:0]       I_OPACK_PIXEL_R,
    input  logic             I_OPACK_PIXEL_VALID,
    input  logic             I_OPACK_FLUSH,
    input  logic             I_OPACK_WREADY,
    output logic [31:0]      O_OPACK_WDATA,
    output logic             O_OPACK_WVALID,
    output logic             O_OPACK_STALL,
    output logic             O_OPACK_OVF,
    output logic             O_OPACK_DONE,
    output logic [CNT_W-1:0] O_OPACK_BYTE_CNT
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] C_CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] C_STALL_LVL = CW'(DEPTH - 1);

    opack_state_t r_state;
    opack_state_t w_state_next;

    logic [1:0]    r_res;        // residue bytes held (0..3)
    logic [23:0]   r_hold;       // residue bytes, lane 0 = oldest
    logic          r_ovf;
    logic          r_stall;

    logic [47:0]   w_cat;
    logic [2:0]    w_total;
    logic          w_need_push;
    logic          w_can_take;
    logic          w_accept;
    logic          w_flush_push;
    logic          w_push;
    logic [31:0]   w_push_data;
    logic          w_pop;
    logic [31:0]   w_head;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_next;
    logic          w_full;
    logic          w_empty;

    // ------------------------------------------------------------------
    // Packer datapath
    // ------------------------------------------------------------------
    assign w_cat       = merge_bytes(r_hold, r_res,
                                     {I_OPACK_PIXEL_R, I_OPACK_PIXEL_G, I_OPACK_PIXEL_B});
    assign w_total     = {1'b0, r_res} + BYTES_PER_PIXEL;
    assign w_need_push = (w_total >= BYTES_PER_WORD);
    assign w_can_take  = (r_state == ST_IDLE) || (r_state == ST_PACK);
    // A triplet that would complete a word cannot be taken while the FIFO
    // is full; it is dropped whole so the residue stays consistent.
    assign w_accept    = I_OPACK_PIXEL_VALID && w_can_take && !(w_need_push && w_full);
    assign w_flush_push = (r_state == ST_FLUSH) && (r_res != 2'd0) && !w_full;
    assign w_push      = (w_accept && w_need_push) || w_flush_push;
    // Residue bytes above r_res are always zero, so the partial word is
    // already zero-padded.
    assign w_push_data = w_flush_push ? {8'h00, r_hold} : w_cat[31:0];
    assign w_pop       = !w_empty && I_OPACK_WREADY;

    always_ff @(posedge I_OPACK_HCLK) begin
        if (!I_OPACK_HRESET_N) begin
            r_res  <= 2'd0;
            r_hold <= 24'd0;
        end else if (w_accept) begin
            // Total is 3..6, so the new residue count is total mod 4.
            r_res  <= w_total[1:0];
            r_hold <= w_need_push ? {8'h00, w_cat[47:32]} : w_cat[23:0];
        end else if (w_flush_push) begin
            r_res  <= 2'd0;
            r_hold <= 24'd0;
        end
    end

    // ------------------------------------------------------------------
    // Word FIFO
    // ------------------------------------------------------------------
    opack_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (I_OPACK_HCLK),
        .rst_n     (I_OPACK_HRESET_N),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head_data (w_head),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign w_count_next = w_count + (w_push ? C_CNT_ONE : '0) - (w_pop ? C_CNT_ONE : '0);

    // STALL leaves one slot of slack for the triplet already in flight.
    always_ff @(posedge I_OPACK_HCLK) begin
        if (!I_OPACK_HRESET_N) begin
            r_stall <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_stall <= (w_count_next >= C_STALL_LVL);
            if (I_OPACK_PIXEL_VALID && !w_accept) r_ovf <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Frame controller
    // ------------------------------------------------------------------
    always_ff @(posedge I_OPACK_HCLK) begin
        if (!I_OPACK_HRESET_N) r_state <= ST_IDLE;
        else                   r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                // With a same-cycle triplet the flush must pass through
                // FLUSH so that the triplet's residue gets emitted.
                if (I_OPACK_FLUSH)            w_state_next = I_OPACK_PIXEL_VALID ? ST_FLUSH : ST_DRAIN;
                else if (I_OPACK_PIXEL_VALID) w_state_next = ST_PACK;
            end
            ST_PACK: begin
                if (I_OPACK_FLUSH) w_state_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                if ((r_res == 2'd0) || w_flush_push) w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_empty) w_state_next = ST_DONE;
            end
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign O_OPACK_WDATA  = w_empty ? 32'd0 : w_head;
    assign O_OPACK_WVALID = !w_empty;
    assign O_OPACK_STALL  = r_stall;
    assign O_OPACK_OVF    = r_ovf;
    assign O_OPACK_DONE   = (r_state == ST_DONE);

`ifdef OPACK_BYTE_CNT_EN
    localparam logic [CNT_W-1:0] C_BYTE_STEP = CNT_W'(BYTES_PER_PIXEL);
    logic [CNT_W-1:0] r_byte_cnt;

    always_ff @(posedge I_OPACK_HCLK) begin
        if (!I_OPACK_HRESET_N || (r_state == ST_DONE)) r_byte_cnt <= '0;
        else if (w_accept)                             r_byte_cnt <= r_byte_cnt + C_BYTE_STEP;
    end

    assign O_OPACK_BYTE_CNT = r_byte_cnt;
`else
    assign O_OPACK_BYTE_CNT = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_output_pack.sv
`default_nettype none
// ============================================================================
// Module   : tb_output_pack
// Purpose  : Self-checking bench for output_pack: vector table for the
//            packing / flush / DONE timing, plus directed sequences for
//            STALL, overflow and reset during drain.
// Revision : 1.0 - initial release
// ============================================================================
module tb_output_pack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  pb, pg, pr;
    logic        pvalid, flush, wready;
    logic [31:0] wdata;
    logic        wvalid, stall, ovf, done;
    logic [15:0] byte_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    output_pack #(.DEPTH(4), .CNT_W(16)) dut (
        .I_OPACK_HCLK        (clk),
        .I_OPACK_HRESET_N    (rst_n),
        .I_OPACK_PIXEL_B     (pb),
        .I_OPACK_PIXEL_G     (pg),
        .I_OPACK_PIXEL_R     (pr),
        .I_OPACK_PIXEL_VALID (pvalid),
        .I_OPACK_FLUSH       (flush),
        .I_OPACK_WREADY      (wready),
        .O_OPACK_WDATA       (wdata),
        .O_OPACK_WVALID      (wvalid),
        .O_OPACK_STALL       (stall),
        .O_OPACK_OVF         (ovf),
        .O_OPACK_DONE        (done),
        .O_OPACK_BYTE_CNT    (byte_cnt)
    );

    typedef struct packed {
        logic        v;
        logic [7:0]  b;
        logic [7:0]  g;
        logic [7:0]  r;
        logic        fl;
        logic        wr;
        logic        e_wv;
        logic [31:0] e_wd;
        logic        e_done;
        logic        e_stall;
        logic        e_ovf;
        logic [15:0] e_cnt;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_cnt(input logic [15:0] c);
`ifdef OPACK_BYTE_CNT_EN
        return c;
`else
        return (c & 16'h0000);
`endif
    endfunction

    task automatic drive(input logic v, input logic [7:0] b, input logic [7:0] g,
                         input logic [7:0] r, input logic fl, input logic wr);
        pvalid = v; pb = b; pg = g; pr = r; flush = fl; wready = wr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Basic packing with WREADY=1, then empty flush
        vecs[0]  = '{1'b1, 8'h01, 8'h02, 8'h03, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 16'd3};
        vecs[1]  = '{1'b1, 8'h04, 8'h05, 8'h06, 1'b0, 1'b1, 1'b1, 32'h04030201, 1'b0, 1'b0, 1'b0, 16'd6};
        vecs[2]  = '{1'b1, 8'h07, 8'h08, 8'h09, 1'b0, 1'b1, 1'b1, 32'h08070605, 1'b0, 1'b0, 1'b0, 16'd9};
        vecs[3]  = '{1'b1, 8'h0A, 8'h0B, 8'h0C, 1'b0, 1'b1, 1'b1, 32'h0C0B0A09, 1'b0, 1'b0, 1'b0, 16'd12};
        vecs[4]  = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 16'd12};
        vecs[5]  = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 16'd12};
        vecs[6]  = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 16'd12};
        vecs[7]  = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 16'd0};
        // Single triplet then flush -> padded word
        vecs[8]  = '{1'b1, 8'h11, 8'h22, 8'h33, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 16'd3};
        vecs[9]  = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 16'd3};
        vecs[10] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 32'h00332211, 1'b0, 1'b0, 1'b0, 16'd3};
        vecs[11] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 16'd3};
        vecs[12] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 16'd3};
        vecs[13] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 16'd0};
        // VALID+FLUSH together with two bytes held
        vecs[14] = '{1'b1, 8'h21, 8'h22, 8'h23, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 16'd3};
        vecs[15] = '{1'b1, 8'h24, 8'h25, 8'h26, 1'b0, 1'b1, 1'b1, 32'h24232221, 1'b0, 1'b0, 1'b0, 16'd6};
        vecs[16] = '{1'b1, 8'h31, 8'h32, 8'h33, 1'b1, 1'b1, 1'b1, 32'h32312625, 1'b0, 1'b0, 1'b0, 16'd9};
        vecs[17] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 32'h00000033, 1'b0, 1'b0, 1'b0, 16'd9};
        vecs[18] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 16'd9};
        vecs[19] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 16'd9};
        vecs[20] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 16'd0};

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        drive(1'b0, 8'h0, 8'h0, 8'h0, 1'b0, 1'b0);
        step();
        step();
        check("reset wvalid", {31'd0, wvalid}, 32'd0);
        check("reset wdata", wdata, 32'd0);
        check("reset stall", {31'd0, stall}, 32'd0);
        check("reset ovf", {31'd0, ovf}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset byte_cnt", {16'd0, byte_cnt}, 32'd0);
        rst_n = 1'b1;

        // ---------------- vector table ----------------
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].v, vecs[i].b, vecs[i].g, vecs[i].r, vecs[i].fl, vecs[i].wr);
            step();
            check($sformatf("vec%0d wvalid", i), {31'd0, wvalid}, {31'd0, vecs[i].e_wv});
            if (vecs[i].e_wv)
                check($sformatf("vec%0d wdata", i), wdata, vecs[i].e_wd);
            check($sformatf("vec%0d done", i), {31'd0, done}, {31'd0, vecs[i].e_done});
            check($sformatf("vec%0d stall", i), {31'd0, stall}, {31'd0, vecs[i].e_stall});
            check($sformatf("vec%0d ovf", i), {31'd0, ovf}, {31'd0, vecs[i].e_ovf});
            check($sformatf("vec%0d byte_cnt", i), {16'd0, byte_cnt}, {16'd0, exp_cnt(vecs[i].e_cnt)});
        end

        // ---------------- STALL with a well-behaved source ----------------
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'h40 + 3*i), 8'(8'h41 + 3*i), 8'(8'h42 + 3*i), 1'b0, 1'b0);
            step();
            check($sformatf("stall after triplet %0d", i), {31'd0, stall}, {31'd0, (i == 3)});
        end
        check("byte_cnt after 4 triplets", {16'd0, byte_cnt}, {16'd0, exp_cnt(16'd12)});
        drive(1'b0, 8'h0, 8'h0, 8'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("held source ovf %0d", i), {31'd0, ovf}, 32'd0);
            check($sformatf("held source stall %0d", i), {31'd0, stall}, 32'd1);
        end
        begin
            logic [31:0] words [3];
            words[0] = 32'h43424140;
            words[1] = 32'h47464544;
            words[2] = 32'h4B4A4948;
            for (int i = 0; i < 3; i++) begin
                check($sformatf("drain word %0d", i), wdata, words[i]);
                check($sformatf("drain wvalid %0d", i), {31'd0, wvalid}, 32'd1);
                wready = 1'b1;
                step();
            end
            wready = 1'b0;
            check("drained wvalid", {31'd0, wvalid}, 32'd0);
            check("drained stall", {31'd0, stall}, 32'd0);
        end

        // ---------------- overflow when STALL is ignored ----------------
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 8'(8'h60 + 3*i), 8'(8'h61 + 3*i), 8'(8'h62 + 3*i), 1'b0, 1'b0);
            step();
            check($sformatf("ovf after push %0d", i), {31'd0, ovf}, {31'd0, (i == 6)});
        end
        drive(1'b0, 8'h0, 8'h0, 8'h0, 1'b0, 1'b0);
        step();
        step();
        check("ovf sticky", {31'd0, ovf}, 32'd1);
        check("full wvalid", {31'd0, wvalid}, 32'd1);
        check("full head", wdata, 32'h63626160);

        // ---------------- reach DRAIN, then reset ----------------
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        wready = 1'b1;
        step();
        wready = 1'b0;
        step();
        step();
        check("drain head", wdata, 32'h67666564);
        check("drain wvalid", {31'd0, wvalid}, 32'd1);
        check("drain done", {31'd0, done}, 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("post-reset wvalid", {31'd0, wvalid}, 32'd0);
        check("post-reset ovf", {31'd0, ovf}, 32'd0);
        check("post-reset stall", {31'd0, stall}, 32'd0);
        check("post-reset byte_cnt", {16'd0, byte_cnt}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("no done after reset %0d", i), {31'd0, done}, 32'd0);
        end
        drive(1'b1, 8'h51, 8'h52, 8'h53, 1'b0, 1'b0);
        step();
        drive(1'b1, 8'h54, 8'h55, 8'h56, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h0, 8'h0, 8'h0, 1'b0, 1'b0);
        check("new frame wvalid", {31'd0, wvalid}, 32'd1);
        check("new frame word lane0", wdata, 32'h54535251);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
